bomb_controller: RTL and testbench
==================================

BOMB_CONTROLLER -- requirements
Module: bomb_controller

Interface
REQ-001 The block SHALL have parameter FUSE_FRAMES, default 90, frames from placement to detonation (range 2..255).
REQ-002 The block SHALL have parameter BLAST_FRAMES, default 15, frames a blast stays active (range 1..255).
REQ-003 The block SHALL have port clk  input  1  system clock.
REQ-004 The block SHALL have port resetN  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port startOfFrame  input  1  one-cycle pulse per frame (30 Hz).
REQ-006 The block SHALL have port place_req  input  1  one-cycle bomb-placement request.
REQ-007 The block SHALL have port tile_col  input  5  player tile column, sampled with place_req.
REQ-008 The block SHALL have port tile_row  input  4  player tile row, sampled with place_req.
REQ-009 The block SHALL have port drawing_request_bomb  input  2  per-slot bomb pixel request, bit i = slot i.
REQ-010 The block SHALL have port drawing_request_blast  input  1  any-blast pixel request.
REQ-011 The block SHALL have port bomb_armed  output  2  slot i holds a ticking bomb.
REQ-012 The block SHALL have port blast_active  output  2  slot i blast is displayed and lethal.
REQ-013 The block SHALL have port bomb_col  output  10  {slot1 col, slot0 col}.
REQ-014 The block SHALL have port bomb_row  output  8  {slot1 row, slot0 row}.
REQ-015 The block SHALL have port place_ack  output  1  one-cycle pulse, placement accepted.
REQ-016 The block SHALL have port place_reject  output  1  one-cycle pulse, placement refused.
REQ-017 The block SHALL have port explode_pulse  output  1  one-cycle pulse on any detonation.

Function
REQ-018 Each of 2 slots SHALL run an independent FSM: IDLE -> ARMED -> BLAST -> IDLE.
REQ-019 Each slot SHALL own an 8-bit frame counter, a 5-bit col, a 4-bit row and a chain flag.
REQ-020 On place_req, the block SHALL accept if any slot is IDLE and no ARMED slot holds the same {tile_col, tile_row}; otherwise reject.
REQ-021 On accept, the lowest-index IDLE slot SHALL load col/row, load counter=FUSE_FRAMES and enter ARMED on the next clk edge.
REQ-022 place_ack or place_reject SHALL assert exactly one cycle, on the cycle after place_req; never both.
REQ-023 A slot leaving BLAST in the same cycle as place_req SHALL count as not IDLE (reject if no other IDLE slot).
REQ-024 Counters SHALL change only in cycles where startOfFrame=1.
REQ-025 In ARMED, on startOfFrame: counter==1 or chain flag set -> enter BLAST, load counter=BLAST_FRAMES; else decrement.
REQ-026 In BLAST, on startOfFrame: counter==1 -> IDLE; else decrement.
REQ-027 Chain flag of an ARMED slot i SHALL set when drawing_request_bomb[i] && drawing_request_blast in the same cycle.
REQ-028 Chain flag SHALL clear on entry to BLAST and on entry to ARMED.
REQ-029 explode_pulse SHALL assert for one cycle, the cycle after any ARMED->BLAST transition; simultaneous detonations give one pulse.
REQ-030 place_req arriving in a startOfFrame cycle SHALL be processed normally; the new bomb's first decrement occurs on the following startOfFrame.
REQ-031 bomb_armed[i] = (state==ARMED), blast_active[i] = (state==BLAST), both registered.
REQ-032 bomb_col/bomb_row SHALL hold the last loaded value in IDLE.

Reset
REQ-033 On resetN=0, all slots SHALL go IDLE and counters, col, row and chain flags SHALL go 0 immediately.
REQ-034 On resetN=0, all outputs SHALL be 0 immediately, including during mid-fuse or mid-blast.

Verification (FUSE_FRAMES=4, BLAST_FRAMES=2)
REQ-035 Basic: place_req at (3,5) -> place_ack next cycle, bomb_armed=01, bomb_col[4:0]=3, bomb_row[3:0]=5.
REQ-036 Basic (cont.): 4th startOfFrame -> blast_active=01 plus one explode_pulse; 2 frames later -> IDLE.
REQ-037 Capacity: 2 accepted places at (1,1) and (2,1), then third at (4,4) -> place_reject, outputs unchanged.
REQ-038 Duplicate: with a bomb at (1,1), place at (1,1) -> place_reject.
REQ-039 Chain: slot0 BLAST; drive drawing_request_bomb=10 with drawing_request_blast=1 for 1 cycle -> slot1 BLAST at next startOfFrame, not at full fuse.
REQ-040 Reset: resetN low mid-fuse -> bomb_armed=00 asynchronously; after release a place_req is acked into slot 0.

Source files
------------

// File: rtl/bomb_controller.sv
// Two-slot bomb manager: placement arbitration, per-slot fuse/blast timing
// and chain detonation when a blast pixel overlaps an armed bomb's pixel.
module bomb_controller #(
    parameter int FUSE_FRAMES  = 90,
    parameter int BLAST_FRAMES = 15
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       place_req,
    input  logic [4:0] tile_col,
    input  logic [3:0] tile_row,
    input  logic [1:0] drawing_request_bomb,
    input  logic       drawing_request_blast,
    output logic [1:0] bomb_armed,
    output logic [1:0] blast_active,
    output logic [9:0] bomb_col,
    output logic [7:0] bomb_row,
    output logic       place_ack,
    output logic       place_reject,
    output logic       explode_pulse
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        BLAST = 2'd2
    } state_t;

    state_t     state   [2];
    state_t     state_n [2];
    logic [7:0] cnt     [2];
    logic [7:0] cnt_n   [2];
    logic [4:0] col     [2];
    logic [4:0] col_n   [2];
    logic [3:0] row     [2];
    logic [3:0] row_n   [2];
    logic       chain   [2];
    logic       chain_n [2];

    logic [1:0] idle;
    logic [1:0] dup;
    logic [1:0] sel;
    logic [1:0] fire;
    logic       accept;

    // Next-state is computed here so the outputs can be registered from it.
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            idle[i] = (state[i] == IDLE);
            dup[i]  = (state[i] == ARMED) && (col[i] == tile_col) && (row[i] == tile_row);
        end
        sel    = {idle[1] & ~idle[0], idle[0]};
        accept = place_req && (|idle) && !(|dup);

        for (int unsigned i = 0; i < 2; i++) begin
            state_n[i] = state[i];
            cnt_n[i]   = cnt[i];
            col_n[i]   = col[i];
            row_n[i]   = row[i];
            chain_n[i] = chain[i];
            fire[i]    = 1'b0;
            case (state[i])
                IDLE: begin
                    if (accept && sel[i]) begin
                        state_n[i] = ARMED;
                        cnt_n[i]   = 8'(FUSE_FRAMES);
                        col_n[i]   = tile_col;
                        row_n[i]   = tile_row;
                        chain_n[i] = 1'b0;
                    end
                end
                ARMED: begin
                    if (startOfFrame && (cnt[i] == 8'd1 || chain[i])) begin
                        state_n[i] = BLAST;
                        cnt_n[i]   = 8'(BLAST_FRAMES);
                        chain_n[i] = 1'b0;
                        fire[i]    = 1'b1;
                    end else begin
                        if (startOfFrame)
                            cnt_n[i] = cnt[i] - 8'd1;
                        if (drawing_request_bomb[i] && drawing_request_blast)
                            chain_n[i] = 1'b1;
                    end
                end
                BLAST: begin
                    if (startOfFrame) begin
                        cnt_n[i] = cnt[i] - 8'd1;
                        if (cnt[i] == 8'd1)
                            state_n[i] = IDLE;
                    end
                end
                default: state_n[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int unsigned i = 0; i < 2; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
                col[i]   <= '0;
                row[i]   <= '0;
                chain[i] <= 1'b0;
            end
            bomb_armed    <= '0;
            blast_active  <= '0;
            bomb_col      <= '0;
            bomb_row      <= '0;
            place_ack     <= 1'b0;
            place_reject  <= 1'b0;
            explode_pulse <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                state[i]        <= state_n[i];
                cnt[i]          <= cnt_n[i];
                col[i]          <= col_n[i];
                row[i]          <= row_n[i];
                chain[i]        <= chain_n[i];
                bomb_armed[i]   <= (state_n[i] == ARMED);
                blast_active[i] <= (state_n[i] == BLAST);
            end
            bomb_col      <= {col_n[1], col_n[0]};
            bomb_row      <= {row_n[1], row_n[0]};
            place_ack     <= accept;
            place_reject  <= place_req && !accept;
            explode_pulse <= |fire;
        end
    end

endmodule

// File: tb/tb_bomb_controller.sv
// Randomized scoreboard bench: a frame-timestamp model predicts each slot's
// detonation/blast-end frame; a negedge monitor compares every DUT output.
module tb_bomb_controller;
    localparam int FUSE  = 4;
    localparam int BLAST = 2;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       sof = 1'b0;
    logic       place_req = 1'b0;
    logic [4:0] tile_col = '0;
    logic [3:0] tile_row = '0;
    logic [1:0] drb = '0;
    logic       dbl = 1'b0;
    logic [1:0] bomb_armed, blast_active;
    logic [9:0] bomb_col;
    logic [7:0] bomb_row;
    logic       place_ack, place_reject, explode_pulse;

    bomb_controller #(.FUSE_FRAMES(FUSE), .BLAST_FRAMES(BLAST)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .place_req(place_req),
        .tile_col(tile_col), .tile_row(tile_row),
        .drawing_request_bomb(drb), .drawing_request_blast(dbl),
        .bomb_armed(bomb_armed), .blast_active(blast_active),
        .bomb_col(bomb_col), .bomb_row(bomb_row),
        .place_ack(place_ack), .place_reject(place_reject), .explode_pulse(explode_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a bomb is described by its detonation frame; blast ends BLAST frames later.
    int         frames;
    int         det  [2];
    bit         busy [2];
    logic [4:0] mcol [2];
    logic [3:0] mrow [2];
    bit         exp_explode;
    bit         ackq [$];

    function automatic bit m_armed(input int i, input int f);
        return busy[i] && f < det[i];
    endfunction

    function automatic bit m_blast(input int i, input int f);
        return busy[i] && f >= det[i] && f < det[i] + BLAST;
    endfunction

    int m_fr, m_fn, m_slot;
    bit m_dup;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frames = 0;
            for (int i = 0; i < 2; i++) begin
                busy[i] = 0; det[i] = 0; mcol[i] = '0; mrow[i] = '0;
            end
            exp_explode = 0;
            ackq.delete();
        end else begin
            m_fr = frames;
            m_fn = frames + (sof ? 1 : 0);
            exp_explode = 0;
            for (int i = 0; i < 2; i++) begin
                if (m_armed(i, m_fr)) begin
                    if (det[i] == m_fn) exp_explode = 1;
                    else if (drb[i] && dbl && m_fn + 1 < det[i]) det[i] = m_fn + 1;
                end
            end
            if (place_req) begin
                m_dup  = 0;
                m_slot = -1;
                for (int i = 1; i >= 0; i--) begin
                    if (m_armed(i, m_fr) && mcol[i] == tile_col && mrow[i] == tile_row) m_dup = 1;
                    if (!m_armed(i, m_fr) && !m_blast(i, m_fr)) m_slot = i;
                end
                if (m_slot >= 0 && !m_dup) begin
                    busy[m_slot] = 1;
                    mcol[m_slot] = tile_col;
                    mrow[m_slot] = tile_row;
                    det[m_slot]  = m_fn + FUSE;
                    ackq.push_back(1'b1);
                end else begin
                    ackq.push_back(1'b0);
                end
            end
            frames = m_fn;
        end
    end

    logic [1:0] e_arm, e_bl;
    bit         e_ack;

    always @(negedge clk) begin
        if (resetN) begin
            for (int i = 0; i < 2; i++) begin
                e_arm[i] = m_armed(i, frames);
                e_bl[i]  = m_blast(i, frames);
            end
            chk("bomb_armed", 32'(bomb_armed), 32'(e_arm));
            chk("blast_active", 32'(blast_active), 32'(e_bl));
            chk("bomb_col", 32'(bomb_col), 32'({mcol[1], mcol[0]}));
            chk("bomb_row", 32'(bomb_row), 32'({mrow[1], mrow[0]}));
            chk("explode_pulse", 32'(explode_pulse), 32'(exp_explode));
            if (ackq.size() > 0) begin
                e_ack = ackq.pop_front();
                chk("place_ack", 32'(place_ack), 32'(e_ack));
                chk("place_reject", 32'(place_reject), 32'(!e_ack));
            end else begin
                chk("no_spurious_ack", 32'(place_ack | place_reject), 32'd0);
            end
        end
    end

    task automatic cyc(input bit s, input bit p, input int c, input int r,
                       input logic [1:0] b, input bit bl);
        sof = s; place_req = p; tile_col = 5'(c); tile_row = 4'(r); drb = b; dbl = bl;
        @(posedge clk);
        #1;
        sof = 0; place_req = 0; drb = '0; dbl = 0;
    endtask

    task automatic frame_gap(input int n);
        for (int k = 0; k < n; k++) begin
            cyc(1, 0, 0, 0, 2'b00, 0);
            cyc(0, 0, 0, 0, 2'b00, 0);
        end
    endtask

    initial begin
        #12;
        chk("reset_armed", 32'(bomb_armed), 32'd0);
        chk("reset_blast", 32'(blast_active), 32'd0);
        chk("reset_col", 32'(bomb_col), 32'd0);
        chk("reset_pulses", 32'({place_ack, place_reject, explode_pulse}), 32'd0);
        resetN = 1'b1;
        @(posedge clk);
        #1;

        // basic fuse and blast
        cyc(0, 1, 3, 5, 2'b00, 0);
        frame_gap(7);

        // duplicate, capacity, then chain into the second slot
        cyc(0, 1, 1, 1, 2'b00, 0);
        cyc(0, 1, 1, 1, 2'b00, 0);
        frame_gap(2);
        cyc(0, 1, 2, 1, 2'b00, 0);
        cyc(0, 1, 4, 4, 2'b00, 0);
        frame_gap(2);
        cyc(0, 0, 0, 0, 2'b10, 1);
        frame_gap(6);

        // asynchronous reset mid-fuse
        cyc(0, 1, 7, 2, 2'b00, 0);
        frame_gap(1);
        #2 resetN = 1'b0;
        #1;
        chk("async_reset_armed", 32'(bomb_armed), 32'd0);
        chk("async_reset_outputs", 32'({blast_active, bomb_col, bomb_row}), 32'd0);
        #3 resetN = 1'b1;
        cyc(0, 1, 9, 3, 2'b00, 0);
        frame_gap(7);

        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                2'($urandom), $urandom_range(0, 7) == 0);
        end
        frame_gap(8);
        chk("ack_queue_drained", 32'(ackq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
